hms_setup_ctrl: RTL and testbench
=================================

# hms_setup_ctrl

Single-clock time-keeping and setup sequencer for the six-digit HH:MM:SS clock. It debounces the three push buttons and runs the CLOCK / SET_SEC / SET_MIN / SET_HOU state machine. It issues one-cycle increment enables to the sec/min/hou counters, all clocked on `clk`, and drives a blink mask so the display can flash the field being edited. It replaces derived-clock sequencing: every output is synchronous to `clk`.

## Interface
- TICK_DIV, 50000000: `clk` cycles per 1 Hz time-keeping tick.
- DEB_DIV, 500000: `clk` cycles per debounce sample strobe (100 Hz).
- BLINK_DIV, 12500000: `clk` cycles per blink phase toggle (2 Hz blink).
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- i_sw0  in  1  raw mode button, active-low, asynchronous.
- i_sw1  in  1  raw position button, active-low, asynchronous.
- i_sw2  in  1  raw increment button, active-low, asynchronous.
- i_sec_max  in  1  seconds counter currently at 59.
- i_min_max  in  1  minutes counter currently at 59.
- o_mode  out  1  0 = CLOCK, 1 = any SET state.
- o_position  out  2  field being edited: 0 = sec, 1 = min, 2 = hou; 0 in CLOCK.
- o_sec_inc  out  1  one-cycle seconds increment enable.
- o_min_inc  out  1  one-cycle minutes increment enable.
- o_hou_inc  out  1  one-cycle hours increment enable.
- o_blink_mask  out  6  per-digit blank request, 1 = blank; [1:0] sec, [3:2] min, [5:4] hou.

## Operation
- **Reset state:** o_mode=0, o_position=0, all inc outputs 0, o_blink_mask=0, all divider counters 0. Debounce history and stable levels reset to 1 (released).
- **Debounce sampling:** the DEB_DIV counter wraps at DEB_DIV-1 and emits a strobe. On each strobe, every button is shifted through a 2-flop synchronizer into a 3-sample history.
- **Debounce decision:** the stable level changes only when all 3 history samples agree and differ from it. A 1→0 stable transition produces a one-cycle internal press pulse.
- **Button held through reset release:** produces a press once 3 low samples have been taken.
- **State transitions:**
  - CLOCK + sw0 → SET_SEC.
  - SET_* + sw0 → CLOCK.
  - sw1 cycles SET_SEC → SET_MIN → SET_HOU → SET_SEC.
  - sw1 and sw2 are ignored in CLOCK.
- **Simultaneous presses:** sw0 has priority. Any sw1/sw2 press in the same cycle is discarded.
- **CLOCK mode counting:** the TICK_DIV counter wraps at TICK_DIV-1, producing a tick. On the tick:
  - o_sec_inc=1.
  - o_min_inc = tick & i_sec_max.
  - o_hou_inc = tick & i_sec_max & i_min_max.
  - The carries assert in the same cycle so all counters update together. Hour wrap is owned by the hour counter.
- **SET mode counting:**
  - The tick counter is held at 0 and no ticks are issued, so time is frozen.
  - A sw2 press asserts only the inc output of the selected field, with no carry, e.g. sec 59→0 leaves minutes unchanged.
- **Leaving SET:** the tick counter restarts from 0, so the first o_sec_inc comes TICK_DIV cycles after the state change.
- **Blink:** a phase bit toggles every BLINK_DIV cycles.
  - Phase is forced to 0 (visible) and the blink counter is cleared on every state change and every accepted sw2 press.
  - o_blink_mask = (SET & phase=1) ? both bits of the selected field : 0.
- **Reset mid-operation:** returns to CLOCK immediately. Any in-flight inc pulse is cleared that cycle.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Tick latency:** o_sec_inc/o_min_inc/o_hou_inc are high for exactly 1 cycle, in the cycle after the tick counter equals TICK_DIV-1.
- **Press latency:** o_sec_inc/o_min_inc/o_hou_inc are high for exactly 1 cycle, 1 cycle after the internal press pulse.
- **Carry inputs:** i_sec_max and i_min_max are sampled in the cycle the tick counter equals TICK_DIV-1.
- **State outputs:** o_mode and o_position update 1 cycle after the press pulse. o_blink_mask follows in the same cycle.
- **Worst-case press latency:** 2 sync cycles + 3 strobes (~3·DEB_DIV cycles) + 2 cycles from the raw edge.
- **No double pulse:** at most one inc pulse per field per cycle. The tick and a sw2 press never coincide because they are mode-exclusive.

## Test plan
Parameter overrides for all scenarios: TICK_DIV=10, DEB_DIV=4, BLINK_DIV=6.

1. Reset, buttons released, i_sec_max=0 → o_sec_inc pulses every 10 cycles for 1 cycle each; o_min_inc=o_hou_inc=0; o_mode=0; o_blink_mask=0.
2. i_sec_max=1, i_min_max=1 at the tick → o_sec_inc, o_min_inc and o_hou_inc all high in the same single cycle. With i_min_max=0, only sec and min pulse.
3. i_sw0 low with 2 glitches shorter than 3 strobes, then held low → exactly one transition to o_mode=1, o_position=0; no o_sec_inc for 50 cycles after entry.
4. In SET: press sw1 three times → o_position steps 1, 2, 0. Press sw2 in position 1 → a single o_min_inc pulse, no o_sec_inc/o_hou_inc, o_blink_mask=000000 on the next cycle.
5. In SET_HOU, idle → o_blink_mask alternates 000000 / 110000 every 6 cycles. Press sw0 → o_mode=0, mask=0, first o_sec_inc exactly 10 cycles after the mode change.
6. sw0 and sw2 stable-low on the same strobe in SET_SEC → o_mode=0, no inc pulse. Assert rst_n=0 mid-pulse → all outputs 0 asynchronously.

Source files
------------

// File: rtl/hms_setup_ctrl.sv
// Time-keeping and setup sequencer for the HH:MM:SS clock: debounces the three
// buttons, runs the CLOCK/SET_* FSM, and issues one-cycle counter enables and a blink mask.
module hms_setup_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DEB_DIV   = 500000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hou_inc,
  output logic [5:0] o_blink_mask
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {ST_CLOCK, ST_SET_SEC, ST_SET_MIN, ST_SET_HOU} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0][2:0] hist_q, hist_d;
  logic [2:0]      stable_q, stable_d, press_q, press_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic            mode_q, mode_d;
  logic [1:0]      position_q, position_d;
  logic            sec_inc_q, sec_inc_d, min_inc_q, min_inc_d, hou_inc_q, hou_inc_d;
  logic [5:0]      mask_q, mask_d;
  logic            deb_strobe, tick_wrap, accept_inc;

  // Synchronizers run every cycle; history only advances on the debounce strobe.
  always_comb begin
    sync1_d    = {i_sw2, i_sw1, i_sw0};
    sync2_d    = sync1_q;
    deb_strobe = (deb_cnt_q == DW'(DEB_DIV - 1));
    deb_cnt_d  = deb_strobe ? '0 : deb_cnt_q + 1'b1;
    hist_d     = hist_q;
    stable_d   = stable_q;
    press_d    = '0;
    for (int b = 0; b < 3; b++) begin
      if (deb_strobe) hist_d[b] = {hist_q[b][1:0], sync2_q[b]};
      if (hist_q[b] == 3'b000 && stable_q[b]) begin
        stable_d[b] = 1'b0;
        press_d[b]  = 1'b1;
      end else if (hist_q[b] == 3'b111 && !stable_q[b]) begin
        stable_d[b] = 1'b1;
      end
    end
  end

  // Mode button wins: a sw0 press discards any sw1/sw2 press in the same cycle.
  always_comb begin
    state_d    = state_q;
    sec_inc_d  = 1'b0;
    min_inc_d  = 1'b0;
    hou_inc_d  = 1'b0;
    accept_inc = 1'b0;
    case (state_q)
      ST_CLOCK:   if (press_q[0]) state_d = ST_SET_SEC;
      ST_SET_SEC: if (press_q[0]) state_d = ST_CLOCK;
                  else if (press_q[1]) state_d = ST_SET_MIN;
                  else if (press_q[2]) begin sec_inc_d = 1'b1; accept_inc = 1'b1; end
      ST_SET_MIN: if (press_q[0]) state_d = ST_CLOCK;
                  else if (press_q[1]) state_d = ST_SET_HOU;
                  else if (press_q[2]) begin min_inc_d = 1'b1; accept_inc = 1'b1; end
      ST_SET_HOU: if (press_q[0]) state_d = ST_CLOCK;
                  else if (press_q[1]) state_d = ST_SET_SEC;
                  else if (press_q[2]) begin hou_inc_d = 1'b1; accept_inc = 1'b1; end
      default:    state_d = ST_CLOCK;
    endcase

    tick_wrap  = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = '0;
    if (state_q == ST_CLOCK) tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    if (state_q == ST_CLOCK && state_d == ST_CLOCK && tick_wrap) begin
      sec_inc_d = 1'b1;
      min_inc_d = i_sec_max;
      hou_inc_d = i_sec_max & i_min_max;
    end
  end

  // Blink restarts visible on every state change or accepted edit.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (state_d != state_q || accept_inc) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    mode_d     = (state_d != ST_CLOCK);
    position_d = 2'd0;
    mask_d     = 6'b000000;
    case (state_d)
      ST_SET_SEC: begin position_d = 2'd0; if (phase_d) mask_d = 6'b000011; end
      ST_SET_MIN: begin position_d = 2'd1; if (phase_d) mask_d = 6'b001100; end
      ST_SET_HOU: begin position_d = 2'd2; if (phase_d) mask_d = 6'b110000; end
      default:    position_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLOCK;
      sync1_q     <= '1;
      sync2_q     <= '1;
      hist_q      <= '1;
      stable_q    <= '1;
      press_q     <= '0;
      deb_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      mode_q      <= 1'b0;
      position_q  <= 2'd0;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hou_inc_q   <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      stable_q    <= stable_d;
      press_q     <= press_d;
      deb_cnt_q   <= deb_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      position_q  <= position_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hou_inc_q   <= hou_inc_d;
      mask_q      <= mask_d;
    end
  end

  assign o_mode       = mode_q;
  assign o_position   = position_q;
  assign o_sec_inc    = sec_inc_q;
  assign o_min_inc    = min_inc_q;
  assign o_hou_inc    = hou_inc_q;
  assign o_blink_mask = mask_q;

endmodule

// File: tb/tb_hms_setup_ctrl.sv
// Directed self-checking bench for hms_setup_ctrl with small dividers
// (TICK_DIV=10, DEB_DIV=4, BLINK_DIV=6).
module tb_hms_setup_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw0 = 1'b1, sw1 = 1'b1, sw2 = 1'b1;
  logic       sec_max = 1'b0, min_max = 1'b0;
  logic       o_mode, o_sec_inc, o_min_inc, o_hou_inc;
  logic [1:0] o_position;
  logic [5:0] o_blink_mask;

  int errors = 0;
  int checks = 0;
  int sec_pulses = 0, min_pulses = 0, hou_pulses = 0, mode_rises = 0;
  logic       mode_prev = 1'b0;
  logic [5:0] mask_at_min = 6'b111111;

  hms_setup_ctrl #(.TICK_DIV(10), .DEB_DIV(4), .BLINK_DIV(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sw0(sw0), .i_sw1(sw1), .i_sw2(sw2),
    .i_sec_max(sec_max), .i_min_max(min_max),
    .o_mode(o_mode), .o_position(o_position),
    .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc), .o_hou_inc(o_hou_inc),
    .o_blink_mask(o_blink_mask)
  );

  always #5 clk = ~clk;

  // Pulse and mode-edge tallies, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_sec_inc) sec_pulses <= sec_pulses + 1;
    if (o_min_inc) begin
      min_pulses  <= min_pulses + 1;
      mask_at_min <= o_blink_mask;
    end
    if (o_hou_inc) hou_pulses <= hou_pulses + 1;
    if (o_mode && !mode_prev) mode_rises <= mode_rises + 1;
    mode_prev <= o_mode;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Holds one button low long enough to debounce, then releases it.
  task automatic applyStimulus(input int idx);
    if (idx == 0) sw0 = 1'b0; else if (idx == 1) sw1 = 1'b0; else sw2 = 1'b0;
    repeat (30) @(negedge clk);
    sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic waitSec(input int limit, output int w);
    w = -1;
    for (int i = 0; i < limit && w < 0; i++) begin
      @(negedge clk);
      if (o_sec_inc) w = i + 1;
    end
  endtask

  task automatic waitMode(input logic v, input int limit, output int w);
    w = -1;
    for (int i = 0; i < limit && w < 0; i++) begin
      @(negedge clk);
      if (o_mode == v) w = i + 1;
    end
  endtask

  task automatic waitMask(input logic [5:0] v, input int limit, output int w);
    w = -1;
    for (int i = 0; i < limit && w < 0; i++) begin
      @(negedge clk);
      if (o_blink_mask == v) w = i + 1;
    end
  endtask

  initial begin
    int w, s0, m0, h0;

    // Reset state and free-running seconds tick.
    repeat (3) @(negedge clk);
    checkOutput("reset_mode", o_mode, 0);
    checkOutput("reset_position", o_position, 0);
    checkOutput("reset_mask", o_blink_mask, 0);
    checkOutput("reset_sec_inc", o_sec_inc, 0);
    rst_n = 1'b1;
    waitSec(20, w);
    checkOutput("first_tick_found", (w > 0), 1);
    waitSec(20, w);
    checkOutput("tick_period", w, 10);
    checkOutput("tick_no_min_carry", o_min_inc, 0);
    checkOutput("tick_no_hou_carry", o_hou_inc, 0);
    checkOutput("clock_mask", o_blink_mask, 0);

    // Carry chain on the tick.
    sec_max = 1'b1; min_max = 1'b1;
    waitSec(20, w);
    checkOutput("carry_period", w, 10);
    checkOutput("carry_min_full", o_min_inc, 1);
    checkOutput("carry_hou_full", o_hou_inc, 1);
    min_max = 1'b0;
    waitSec(20, w);
    checkOutput("carry_min_only", o_min_inc, 1);
    checkOutput("carry_no_hou", o_hou_inc, 0);
    sec_max = 1'b0;

    // Glitchy mode button, then a real hold.
    for (int g = 0; g < 2; g++) begin
      sw0 = 1'b0;
      repeat (5) @(negedge clk);
      sw0 = 1'b1;
      repeat (12) @(negedge clk);
    end
    checkOutput("glitch_ignored", o_mode, 0);
    sw0 = 1'b0;
    waitMode(1'b1, 40, w);
    checkOutput("enter_set_found", (w > 0), 1);
    checkOutput("enter_set_position", o_position, 0);
    s0 = sec_pulses;
    repeat (50) @(negedge clk);
    checkOutput("set_time_frozen", sec_pulses - s0, 0);
    sw0 = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("set_after_release", o_mode, 1);
    checkOutput("single_mode_entry", mode_rises, 1);

    // Position cycling and a minutes edit.
    applyStimulus(1);
    checkOutput("pos_step1", o_position, 1);
    applyStimulus(1);
    checkOutput("pos_step2", o_position, 2);
    applyStimulus(1);
    checkOutput("pos_step0", o_position, 0);
    applyStimulus(1);
    checkOutput("pos_back1", o_position, 1);
    s0 = sec_pulses; m0 = min_pulses; h0 = hou_pulses;
    applyStimulus(2);
    checkOutput("edit_sec_delta", sec_pulses - s0, 0);
    checkOutput("edit_min_delta", min_pulses - m0, 1);
    checkOutput("edit_hou_delta", hou_pulses - h0, 0);
    checkOutput("edit_mask_visible", mask_at_min, 0);

    // Hours field blink cadence, then exit to CLOCK.
    applyStimulus(1);
    checkOutput("pos_hou", o_position, 2);
    waitMask(6'b000000, 20, w);
    waitMask(6'b110000, 20, w);
    checkOutput("blink_on_found", (w > 0), 1);
    waitMask(6'b000000, 20, w);
    checkOutput("blink_on_len", w, 6);
    waitMask(6'b110000, 20, w);
    checkOutput("blink_off_len", w, 6);
    sw0 = 1'b0;
    waitMode(1'b0, 40, w);
    checkOutput("exit_set_found", (w > 0), 1);
    checkOutput("exit_mask", o_blink_mask, 0);
    waitSec(20, w);
    checkOutput("exit_first_tick", w, 10);
    sw0 = 1'b1;
    repeat (30) @(negedge clk);

    // Simultaneous sw0+sw2 in SET_SEC, then reset mid-pulse.
    applyStimulus(0);
    checkOutput("reenter_mode", o_mode, 1);
    checkOutput("reenter_position", o_position, 0);
    s0 = sec_pulses; m0 = min_pulses; h0 = hou_pulses;
    sw0 = 1'b0; sw2 = 1'b0;
    waitMode(1'b0, 40, w);
    checkOutput("simul_exit_found", (w > 0), 1);
    repeat (5) @(negedge clk);
    checkOutput("simul_no_inc", (sec_pulses - s0) + (min_pulses - m0) + (hou_pulses - h0), 0);
    sw0 = 1'b1; sw2 = 1'b1;
    waitSec(20, w);
    checkOutput("pre_reset_pulse", o_sec_inc, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_sec_inc", o_sec_inc, 0);
    checkOutput("async_reset_mode", o_mode, 0);
    checkOutput("async_reset_mask", o_blink_mask, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
